// File: rtl/rx_phy.sv
// rtl/rx_phy.sv - Alink RTZ dual-rail receive PHY: lane mux, sync, symbol filter, word assembly.
// Optional stability filter enabled by defining ALINK_RX_FILTER_EN.
module rx_phy #(
  parameter int PHY_NUM  = 32,
  parameter int FILT_LEN = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               reg_flush,
  input  logic               task_id_vld,
  input  logic [31:0]        rx_phy_sel,
  input  logic [31:0]        reg_tout,
  input  logic [PHY_NUM-1:0] RX_P,
  input  logic [PHY_NUM-1:0] RX_N,
  output logic [31:0]        rx_din,
  output logic               rx_wr_en,
  input  logic               rx_full,
  output logic               rx_phy_done,
  output logic               rx_phy_tout,
  output logic               rx_phy_err,
  output logic               rx_ovf,
  output logic [7:0]         rx_word_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_WAIT_BIT, S_WAIT_SPC} state_t;

  localparam logic [1:0] SYM_STOP = 2'b11;
  localparam logic [1:0] SYM_SPC  = 2'b00;
  localparam logic [1:0] SYM_ONE  = 2'b10;
  localparam logic [1:0] SYM_ZERO = 2'b01;

  // The run counter saturates at FILT_LEN in both builds; only the acceptance threshold differs.
  localparam logic [3:0] FILT_SAT = 4'(FILT_LEN);
`ifdef ALINK_RX_FILTER_EN
  localparam logic [3:0] FILT_THR = 4'(FILT_LEN);
`else
  localparam logic [3:0] FILT_THR = 4'd1;
`endif

  state_t               state, state_n;
  logic [PHY_NUM-1:0]   sel_q;
  logic [31:0]          tout_cnt;
  logic [1:0]           lane_pair, sync1, sync2, acc_q;
  logic [3:0]           run_q;
  logic                 sym_evt;
  logic [31:0]          sreg;
  logic [4:0]           bit_cnt;
  logic                 push_q;
  logic                 done_q, tout_q, err_q, ovf_q;
  logic [7:0]           word_cnt;
  logic                 done_n, err_n, tout_n, shift_en, arm, end_frame;

  // Lowest set select bit wins; an unselected lane reads as idle.
  always_comb begin
    lane_pair = SYM_STOP;
    for (int i = PHY_NUM - 1; i >= 0; i--) begin
      if (sel_q[i]) lane_pair = {RX_P[i], RX_N[i]};
    end
  end

  assign sym_evt = (run_q >= FILT_THR) && (sync2 != acc_q);

  always_comb begin
    state_n   = state;
    done_n    = 1'b0;
    err_n     = 1'b0;
    tout_n    = 1'b0;
    shift_en  = 1'b0;
    arm       = 1'b0;
    end_frame = 1'b0;
    if (reg_flush) begin
      state_n = S_IDLE;
    end else if (state == S_IDLE) begin
      if (task_id_vld) begin
        arm     = 1'b1;
        state_n = S_ARMED;
      end
    end else if (tout_cnt == 32'd1) begin
      state_n = S_IDLE;
      tout_n  = 1'b1;
    end else if (sym_evt) begin
      case (state)
        S_ARMED: if (sync2 == SYM_SPC) state_n = S_WAIT_BIT;
        S_WAIT_BIT: begin
          if (sync2 == SYM_ONE || sync2 == SYM_ZERO) begin
            shift_en = 1'b1;
            state_n  = S_WAIT_SPC;
          end else if (sync2 == SYM_STOP) begin
            end_frame = 1'b1;
          end
        end
        S_WAIT_SPC: begin
          if (sync2 == SYM_SPC) begin
            state_n = S_WAIT_BIT;
          end else if (sync2 == SYM_STOP) begin
            end_frame = 1'b1;
          end else begin
            err_n   = 1'b1;
            state_n = S_IDLE;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
    if (end_frame) begin
      state_n = S_IDLE;
      done_n  = (bit_cnt == 5'd0);
      err_n   = (bit_cnt != 5'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      sel_q    <= '0;
      tout_cnt <= '0;
      sync1    <= SYM_STOP;
      sync2    <= SYM_STOP;
      acc_q    <= SYM_STOP;
      run_q    <= '0;
      sreg     <= '0;
      bit_cnt  <= '0;
      push_q   <= 1'b0;
      done_q   <= 1'b0;
      tout_q   <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      word_cnt <= '0;
    end else begin
      state  <= state_n;
      sync1  <= lane_pair;
      sync2  <= sync1;
      if (sync1 != sync2) run_q <= 4'd1;
      else if (run_q != FILT_SAT) run_q <= run_q + 4'd1;
      if (sym_evt) acc_q <= sync2;
      done_q <= done_n;
      tout_q <= tout_n;
      err_q  <= err_n;
      push_q <= shift_en && (bit_cnt == 5'd31);
      if (shift_en) begin
        sreg    <= {sync2 == SYM_ONE, sreg[31:1]};
        bit_cnt <= bit_cnt + 5'd1;
      end
      if (arm) begin
        sel_q    <= rx_phy_sel[PHY_NUM-1:0];
        tout_cnt <= reg_tout;
        bit_cnt  <= '0;
        word_cnt <= '0;
        ovf_q    <= 1'b0;
      end else if (state != S_IDLE && tout_cnt != 32'd0) begin
        tout_cnt <= tout_cnt - 32'd1;
      end
      // A completed word is pushed even if the frame ends in the same cycle.
      if (push_q) begin
        if (rx_full) ovf_q <= 1'b1;
        else if (word_cnt != 8'hFF) word_cnt <= word_cnt + 8'd1;
      end
    end
  end

  assign rx_din      = sreg;
  assign rx_wr_en    = push_q && !rx_full;
  assign rx_phy_done = done_q;
  assign rx_phy_tout = tout_q;
  assign rx_phy_err  = err_q;
  assign rx_ovf      = ovf_q;
  assign rx_word_cnt = word_cnt;

endmodule
